// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scan scheduler with anti-ghost blanking, 16-level brightness,
// leading-zero blanking and per-digit blink.
module seg_scan_ctrl #(
  parameter int CLK_HZ    = 27000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 270,
  parameter int BLINK_CYC = CLK_HZ / 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  bright,
  input  logic        lz_blank,
  input  logic [3:0]  blink_mask,
  output logic [6:0]  seg,
  output logic [3:0]  dig_sel,
  output logic        frame_done
);
  localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int STEP     = (SLOT_CYC - BLANK_CYC) / 16;
  localparam int CW       = $clog2(SLOT_CYC);
  localparam int BW       = BLINK_CYC > 1 ? $clog2(BLINK_CYC) : 1;
  typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;
  state_t state, state_n;
  logic [CW-1:0] slot_cnt, slot_cnt_n, on_last;
  logic [1:0] idx, idx_n;
  logic [3:0] s_nib, s_bright, s_mask;
  logic s_lz, slot_end, snap, dark, blink_off, blink_off_n;
  logic [BW-1:0] blink_cnt;
  logic [6:0] dec;
  assign on_last     = CW'(BLANK_CYC + (int'(s_bright) + 1) * STEP - 1);
  assign slot_end    = state != IDLE && slot_cnt == CW'(SLOT_CYC - 1);
  assign snap        = enable && (state == IDLE || slot_end);
  assign blink_off_n = blink_cnt == BW'(BLINK_CYC - 1) ? ~blink_off : blink_off;
  // blink uses the phase that becomes current on this edge so outputs track it without lag
  assign dark = s_nib > 4'd9 || (idx == 2'd3 && s_lz && s_nib == 4'd0) || (s_mask[idx] && blink_off_n);
  always_comb begin
    state_n    = state;
    slot_cnt_n = slot_cnt + CW'(1);
    idx_n      = idx;
    if (!enable || state == IDLE) begin
      state_n    = enable ? BLANK : IDLE;
      slot_cnt_n = '0;
      idx_n      = '0;
    end else if (slot_end) begin
      state_n    = BLANK;
      slot_cnt_n = '0;
      idx_n      = idx + 2'd1;
    end else if (state == BLANK && slot_cnt == CW'(BLANK_CYC - 1)) begin
      state_n = ON;
    end else if (state == ON && slot_cnt == on_last) begin
      state_n = OFF;
    end
  end
  always_comb begin
    case (s_nib)
      4'd0: dec = 7'h3F;
      4'd1: dec = 7'h06;
      4'd2: dec = 7'h5B;
      4'd3: dec = 7'h4F;
      4'd4: dec = 7'h66;
      4'd5: dec = 7'h6D;
      4'd6: dec = 7'h7D;
      4'd7: dec = 7'h07;
      4'd8: dec = 7'h7F;
      4'd9: dec = 7'h6F;
      default: dec = 7'h00;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      blink_off  <= 1'b0;
      s_nib      <= '0;
      s_bright   <= '0;
      s_mask     <= '0;
      s_lz       <= 1'b0;
      seg        <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      slot_cnt   <= slot_cnt_n;
      idx        <= idx_n;
      blink_cnt  <= blink_cnt == BW'(BLINK_CYC - 1) ? '0 : blink_cnt + BW'(1);
      blink_off  <= blink_off_n;
      if (snap) begin
        s_nib    <= digits[{idx_n, 2'b00} +: 4];
        s_bright <= bright;
        s_mask   <= blink_mask;
        s_lz     <= lz_blank;
      end
      seg        <= state_n == ON && !dark ? dec : '0;
      dig_sel    <= state_n == ON && !dark ? 4'b0001 << idx : '0;
      frame_done <= enable && slot_end && idx == 2'd3;
    end
  end
endmodule
